// File: rtl/flag_pkg.sv
// flag_pkg: shared widths, FSM encoding and defaults for the flag sequencer
package flag_pkg;
  localparam int FLAG_IDX_W = 8;
  localparam int DEFAULT_AUTO_FRAMES = 180;
  typedef enum logic {S_MANUAL = 1'b0, S_AUTO = 1'b1} state_t;
endpackage

// File: rtl/btn_frame_sampler.sv
// btn_frame_sampler: 2-FF sync, frame-rate sample and rising-edge press pulse
module btn_frame_sampler (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn,
  output logic press
);
  logic s1, s2, smp, armed;
  // armed blocks a press until the button has been seen released, so a
  // button held through reset does not fire on release of reset
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      smp <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (frame_tick) begin
        smp <= s2;
        armed <= armed | ~s2;
      end
    end
  assign press = frame_tick & s2 & ~smp & armed;
endmodule

// File: rtl/flag_sequencer.sv
// flag_sequencer: frame-synchronous flag selector with manual and auto-advance modes
module flag_sequencer
  import flag_pkg::*;
#(
  parameter int AUTO_FRAMES = DEFAULT_AUTO_FRAMES,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic                  auto_en,
  input  logic [FLAG_IDX_W-1:0] count,
  output logic [FLAG_IDX_W-1:0] selector,
  output logic                  changed,
  output logic                  auto_active
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(AUTO_FRAMES - 1);
  logic a1, a2, pn, pp, expiry, adv, back;
  state_t state, state_n;
  logic [CNT_W-1:0] dwell, dwell_n;
  logic [FLAG_IDX_W-1:0] sel_n;
  btn_frame_sampler u_next (.clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn_next), .press(pn));
  btn_frame_sampler u_prev (.clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn_prev), .press(pp));
  // selector>=count also covers count==0; simultaneous presses cancel out
  always_comb begin
    state_n = frame_tick ? (a2 ? S_AUTO : S_MANUAL) : state;
    expiry = frame_tick && state == S_AUTO && a2 && dwell == LAST;
    adv = expiry | (pn & ~pp);
    back = pp & ~pn;
    sel_n = !frame_tick ? selector :
            selector >= count ? '0 :
            adv ? (selector == count - 8'd1 ? '0 : selector + 8'd1) :
            back ? (selector == 8'd0 ? count - 8'd1 : selector - 8'd1) : selector;
    dwell_n = state_n != state ? '0 :
              !(frame_tick && state == S_AUTO) ? dwell :
              (expiry || (pn ^ pp)) ? '0 : dwell + CNT_W'(1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      a1 <= 1'b0;
      a2 <= 1'b0;
      state <= S_MANUAL;
      dwell <= '0;
      selector <= '0;
      changed <= 1'b0;
    end else begin
      a1 <= auto_en;
      a2 <= a1;
      state <= state_n;
      dwell <= dwell_n;
      selector <= sel_n;
      changed <= sel_n != selector;
    end
  assign auto_active = state == S_AUTO;
endmodule

// File: tb/tb_flag_sequencer.sv
// tb_flag_sequencer: directed self-checking bench for flag_sequencer (AUTO_FRAMES=4)
module tb_flag_sequencer;
  logic clk = 1'b0, rst, frame_tick, btn_next, btn_prev, auto_en, changed, auto_active;
  logic [7:0] count, selector;
  int checks = 0, errors = 0, pulses = 0, p0;

  flag_sequencer #(.AUTO_FRAMES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_next(btn_next),
    .btn_prev(btn_prev), .auto_en(auto_en), .count(count),
    .selector(selector), .changed(changed), .auto_active(auto_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (changed) pulses <= pulses + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    repeat (4) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press_chk(input logic nx, input logic pv, input int exp_sel, input int exp_chg, input string tag);
    btn_next = nx;
    btn_prev = pv;
    frame();
    chk({tag, "_sel"}, selector, exp_sel);
    chk({tag, "_chg"}, changed, exp_chg);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    frame();
    chk({tag, "_rel"}, selector, exp_sel);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; count = 8'd45;
    repeat (3) @(negedge clk);
    chk("rst_sel", selector, 0);
    chk("rst_chg", changed, 0);
    chk("rst_auto", auto_active, 0);
    rst = 1'b0;
    frame();
    chk("idle_sel", selector, 0);
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1;
      frame();
      chk("next_sel", selector, i + 1);
      chk("next_chg", changed, 1);
      frame();
      chk("hold_sel", selector, i + 1);
      chk("hold_chg", changed, 0);
      btn_next = 1'b0;
      frame();
    end
    chk("pulses3", pulses - p0, 3);
    for (int i = 0; i < 4; i++) press_chk(1'b0, 1'b1, (i < 3) ? 2 - i : 44, 1, "prev");
    press_chk(1'b1, 1'b0, 0, 1, "next_wrap");
    press_chk(1'b0, 1'b1, 44, 1, "prev_wrap");
    press_chk(1'b1, 1'b0, 0, 1, "next_wrap2");
    p0 = pulses;
    press_chk(1'b1, 1'b1, 0, 0, "both");
    count = 8'd1;
    press_chk(1'b1, 1'b0, 0, 0, "cnt1_next");
    press_chk(1'b0, 1'b1, 0, 0, "cnt1_prev");
    chk("no_pulses", pulses - p0, 0);
    count = 8'd45;
    press_chk(1'b0, 1'b1, 44, 1, "to44");
    for (int i = 0; i < 4; i++) press_chk(1'b0, 1'b1, 43 - i, 1, "to40");
    count = 8'd10;
    frame();
    chk("shrink_sel", selector, 0);
    chk("shrink_chg", changed, 1);
    @(negedge clk);
    chk("chg_one_cycle", changed, 0);
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    frame();
    chk("toggle_sel", selector, 0);
    chk("toggle_chg", changed, 0);
    count = 8'd0;
    frame();
    chk("cnt0_sel", selector, 0);
    chk("cnt0_chg", changed, 0);
    count = 8'd3;
    auto_en = 1'b1;
    frame();
    chk("auto_on", auto_active, 1);
    chk("auto_on_sel", selector, 0);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) begin
        frame();
        chk("dwell_hold", selector, (k - 1) % 3);
      end
      frame();
      chk("auto_adv", selector, k % 3);
      chk("auto_chg", changed, 1);
    end
    frame();
    frame();
    press_chk(1'b1, 1'b0, 1, 1, "auto_press");
    frame();
    chk("restart1", selector, 1);
    frame();
    chk("restart2", selector, 1);
    frame();
    chk("restart_adv", selector, 2);
    repeat (3) frame();
    press_chk(1'b1, 1'b0, 0, 1, "next_and_expiry");
    count = 8'd10;
    for (int i = 0; i < 7; i++) press_chk(1'b1, 1'b0, i + 1, 1, "auto_step");
    frame();
    frame();
    chk("pre_rst_dwell", dut.dwell, 3);
    chk("pre_rst_sel", selector, 7);
    btn_next = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", selector, 0);
    chk("mid_rst_auto", auto_active, 0);
    chk("mid_rst_dwell", dut.dwell, 0);
    chk("mid_rst_chg", changed, 0);
    auto_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    frame();
    chk("held_sel", selector, 0);
    chk("held_chg", changed, 0);
    frame();
    chk("held2_sel", selector, 0);
    btn_next = 1'b0;
    frame();
    chk("released_sel", selector, 0);
    press_chk(1'b1, 1'b0, 1, 1, "repress");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_sequencer.md
Name: flag_sequencer

Overview:
- Upstream control stage for the flag lookup mux: produces the 8-bit flag selector that the per-pixel colour mux consumes.
- Steps through flags 0..count-1 on next/prev buttons, or automatically after a programmable dwell time.
- Updates only at frame boundaries, so a flag never changes mid-frame.
- Takes the mux's flag count as an input, so adding flags needs no change here.

Parameters:
- AUTO_FRAMES, 180, frames per flag in auto mode (3 s at 60 Hz); legal range 1..65535.
- CNT_W, 16, dwell counter width; must satisfy 2^CNT_W > AUTO_FRAMES.

Ports:
- clk  input  1  pixel clock; the only clock.
- rst  input  1  reset; synchronous to clk, active-high.
- frame_tick  input  1  one-cycle pulse at start of each frame (pix_x==0 && pix_y==0).
- btn_next  input  1  raw asynchronous button, advance.
- btn_prev  input  1  raw asynchronous button, go back.
- auto_en  input  1  level; 1 = auto-advance mode.
- count  input  8  number of valid flags from the colour mux.
- selector  output  8  registered flag index to the colour mux.
- changed  output  1  one-cycle pulse in the cycle selector takes a new value.
- auto_active  output  1  registered; 1 while FSM is in S_AUTO.

Behaviour:
- Reset, applied at the clk edge with rst=1, mid-operation included:
  - selector=0, changed=0, auto_active=0.
  - FSM=S_MANUAL, dwell=0.
  - Sync and sample registers=0.
- Input synchronisation: btn_next, btn_prev and auto_en each pass through a 2-FF synchroniser.
- Button sampling (frame-rate debounce):
  - Synchronised buttons are sampled only on frame_tick into nxt_s and prv_s.
  - A press is nxt_s rising between two consecutive frame ticks (same for prv_s).
  - Holding a button produces exactly one press.
- FSM:
  - S_MANUAL -> S_AUTO when synced auto_en=1, evaluated at frame_tick.
  - S_AUTO -> S_MANUAL when synced auto_en=0, evaluated at frame_tick.
  - dwell clears on every transition.
  - auto_active is registered from the state.
- Dwell counter:
  - Counts only in S_AUTO, on frame_tick.
  - When dwell==AUTO_FRAMES-1 at a tick: advance selector and clear dwell.
  - A manual press in S_AUTO also clears dwell (restarts the dwell period).
- Update rules, evaluated at frame_tick only, in priority order:
  1. count==0: selector=0; no change pulse unless the value actually changes.
  2. selector>=count (count shrank): selector=0.
  3. Next and prev presses in the same tick: both ignored; dwell is not cleared.
  4. Next press, or auto expiry: selector = (selector==count-1) ? 0 : selector+1.
  5. Prev press: selector = (selector==0) ? count-1 : selector-1.
  6. Next press and auto expiry in the same tick: single advance of +1, never +2.
- Latency:
  - selector updates on the clk edge that samples frame_tick, and is stable for the entire following frame.
  - changed is asserted in the cycle after that edge, aligned with the new selector value, for exactly one cycle.
  - Press-to-selector latency is 1 frame from first sampled high (2 sync cycles plus the tick).
- Arithmetic:
  - All index math is 8-bit unsigned; wrap is by explicit compare, never by modulo overflow.
  - count=1: next and prev both leave selector at 0, and changed stays 0.
- Outside frame_tick no state changes except the synchronisers.

Decomposition:
- Shared package (flag_pkg):
  - FLAG_IDX_W=8.
  - FSM state encoding: S_MANUAL=1'b0, S_AUTO=1'b1.
  - DEFAULT_AUTO_FRAMES=180.
- Sub-module: btn_frame_sampler (2-FF sync, frame-tick sample, rising-edge press pulse), instantiated twice for next and prev.
- auto_en uses a plain 2-FF synchroniser inline.

Test Plan:
- Reset, count=45, three next presses (each held 2 frames) -> selector 0,1,2,3; exactly 3 changed pulses.
- selector=44, count=45, next press -> 0. Then prev press -> 44.
- auto_en=1, AUTO_FRAMES=4, count=3 -> selector advances every 4 frame ticks: 0,1,2,0. A next press at dwell=2 gives one advance and restarts dwell, so the following auto advance comes 4 ticks later.
- Next and prev asserted together -> selector unchanged, no changed pulse. Same case with count=1 and a next press -> stays 0, no pulse.
- selector=40, count drops to 10 -> at next frame_tick selector=0 with changed=1. Button toggled between frame ticks only -> no press detected.
- Reset asserted mid-auto with dwell=3, selector=7 -> next cycle: selector=0, auto_active=0, dwell=0. Button held through reset release -> no press until released and pressed again.
